// File: rtl/iot_zone_monitor.sv
// rtl/iot_zone_monitor.sv - per-zone saturating device counters, running total, hysteretic load alarm
module iot_zone_monitor #(
    parameter int WIDTH     = 8,
    parameter int N_ZONES   = 4,
    parameter int ZONE_W    = 2,
    parameter int MAX_COUNT = 255,
    parameter int ALARM_HI  = 200,
    parameter int ALARM_LO  = 150,
    parameter int TOTAL_W   = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       change,
    input  logic                       on_off,
    input  logic [ZONE_W-1:0]          zone,
    input  logic                       clear_err,
    output logic [N_ZONES*WIDTH-1:0]   counts_out,
    output logic [TOTAL_W-1:0]         total_out,
    output logic [N_ZONES-1:0]         zone_full,
    output logic                       alarm,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic                       err_zone
);

    typedef enum logic {S_IDLE, S_ALARM} state_t;

    logic [WIDTH-1:0]       count_q [N_ZONES];
    logic [TOTAL_W-1:0]     total_q, total_d;
    logic [WIDTH-1:0]       cur_count;
    logic [2**ZONE_W-1:0]   zone_valid;
    logic                   zone_ok, do_inc, do_dec, ovf_evt, unf_evt, zone_evt;
    state_t                 state_q, state_d;

    // Validity table avoids a constant comparison when 2**ZONE_W == N_ZONES.
    always_comb begin
        zone_valid = '0;
        for (int i = 0; i < 2**ZONE_W; i++) begin
            zone_valid[i] = (i < N_ZONES);
        end
        zone_ok   = zone_valid[zone];
        cur_count = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (zone == ZONE_W'(i)) cur_count = count_q[i];
        end
        do_inc   = change && zone_ok &&  on_off && (cur_count != WIDTH'(MAX_COUNT));
        ovf_evt  = change && zone_ok &&  on_off && (cur_count == WIDTH'(MAX_COUNT));
        do_dec   = change && zone_ok && !on_off && (cur_count != '0);
        unf_evt  = change && zone_ok && !on_off && (cur_count == '0);
        zone_evt = change && !zone_ok;
        total_d  = total_q;
        if (do_inc)      total_d = total_q + TOTAL_W'(1);
        else if (do_dec) total_d = total_q - TOTAL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ZONES; i++) count_q[i] <= '0;
            total_q       <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_zone      <= 1'b0;
        end else begin
            for (int i = 0; i < N_ZONES; i++) begin
                if (zone == ZONE_W'(i)) begin
                    if (do_inc)      count_q[i] <= count_q[i] + WIDTH'(1);
                    else if (do_dec) count_q[i] <= count_q[i] - WIDTH'(1);
                end
            end
            total_q       <= total_d;
            // A same-cycle error event overrides the clear.
            err_overflow  <= (err_overflow  & ~clear_err) | ovf_evt;
            err_underflow <= (err_underflow & ~clear_err) | unf_evt;
            err_zone      <= (err_zone      & ~clear_err) | zone_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (total_d >= TOTAL_W'(ALARM_HI)) state_d = S_ALARM;
            S_ALARM: if (total_d <= TOTAL_W'(ALARM_LO)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_ZONES; i++) begin
            counts_out[i*WIDTH +: WIDTH] = count_q[i];
            zone_full[i] = (count_q[i] == WIDTH'(MAX_COUNT));
        end
    end

    assign total_out = total_q;
    assign alarm     = (state_q == S_ALARM);

endmodule

// File: tb/tb_iot_zone_monitor.sv
// tb/tb_iot_zone_monitor.sv - scoreboard bench for iot_zone_monitor built with three zones
module tb_iot_zone_monitor;

    logic        clk = 1'b0;
    logic        rst, change, on_off, clear_err;
    logic [1:0]  zone;
    logic [23:0] counts_out;
    logic [11:0] total_out;
    logic [2:0]  zone_full;
    logic        alarm, err_overflow, err_underflow, err_zone;

    typedef struct packed {
        logic [23:0] counts;
        logic [11:0] total;
        logic [2:0]  full;
        logic        alarm;
        logic        ovf;
        logic        unf;
        logic        zerr;
    } snap_t;

    snap_t obs, e;
    snap_t sb[$];
    int    tests_run = 0, tests_failed = 0;
    int    m_cnt[3];
    int    m_total;
    logic  m_alarm, m_ovf, m_unf, m_zerr;

    assign obs = {counts_out, total_out, zone_full, alarm, err_overflow, err_underflow, err_zone};

    always #5 clk = ~clk;

    iot_zone_monitor #(
        .WIDTH(8), .N_ZONES(3), .ZONE_W(2), .MAX_COUNT(255),
        .ALARM_HI(200), .ALARM_LO(150), .TOTAL_W(12)
    ) dut (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off), .zone(zone),
        .clear_err(clear_err), .counts_out(counts_out), .total_out(total_out),
        .zone_full(zone_full), .alarm(alarm), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .err_zone(err_zone)
    );

    task automatic apply(input logic r, input logic ch, input logic oo,
                         input logic [1:0] z, input logic ce);
        snap_t x;
        rst = r; change = ch; on_off = oo; zone = z; clear_err = ce;
        if (r) begin
            m_cnt = '{0, 0, 0};
            m_total = 0; m_alarm = 0; m_ovf = 0; m_unf = 0; m_zerr = 0;
        end else begin
            if (ce) begin m_ovf = 0; m_unf = 0; m_zerr = 0; end
            if (ch) begin
                if (z >= 2'd3) m_zerr = 1;
                else if (oo) begin
                    if (m_cnt[z] == 255) m_ovf = 1;
                    else begin m_cnt[z]++; m_total++; end
                end else begin
                    if (m_cnt[z] == 0) m_unf = 1;
                    else begin m_cnt[z]--; m_total--; end
                end
            end
            if (!m_alarm && m_total >= 200)     m_alarm = 1;
            else if (m_alarm && m_total <= 150) m_alarm = 0;
        end
        x.counts = {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
        x.total  = 12'(m_total);
        x.full   = {m_cnt[2] == 255, m_cnt[1] == 255, m_cnt[0] == 255};
        x.alarm  = m_alarm; x.ovf = m_ovf; x.unf = m_unf; x.zerr = m_zerr;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        void'(sb.pop_front());
        e = sb.pop_front();
        tests_run++;
        if (obs !== 43'h0 || obs !== e) begin
            tests_failed++;
            $display("FAIL reset_state got=%h want=%h", obs, e);
        end
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 2'd1, 0);
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_up_down();
        apply(1, 0, 0, 0, 0); void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            apply(0, 1, i < 5, 2'd1, 0);
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL up_down step=%0d got=%h want=%h", i, obs, e);
            end
        end
        tests_run++;
        if (counts_out !== 24'h000300 || total_out !== 12'd3) begin
            tests_failed++;
            $display("FAIL up_down_final counts=%h total=%0d want counts=000300 total=3", counts_out, total_out);
        end
    endtask

    task automatic test_overflow();
        apply(1, 0, 0, 0, 0); void'(sb.pop_front());
        for (int i = 0; i < 256; i++) begin
            apply(0, 1, 1, 2'd0, 0);
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL overflow step=%0d got=%h want=%h", i, obs, e);
            end
        end
        tests_run++;
        if (counts_out[7:0] !== 8'd255 || zone_full !== 3'b001 || err_overflow !== 1'b1 || total_out !== 12'd255) begin
            tests_failed++;
            $display("FAIL overflow_final cnt=%0d full=%b ovf=%b total=%0d want 255/001/1/255",
                     counts_out[7:0], zone_full, err_overflow, total_out);
        end
        apply(0, 0, 0, 0, 1);
        e = sb.pop_front();
        tests_run++;
        if (obs !== e || err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_err got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_underflow_zone();
        apply(1, 0, 0, 0, 0); void'(sb.pop_front());
        apply(0, 1, 1, 2'd1, 0); void'(sb.pop_front());
        apply(0, 1, 0, 2'd2, 0);
        e = sb.pop_front();
        tests_run++;
        if (obs !== e || err_underflow !== 1'b1 || counts_out[23:16] !== 8'd0) begin
            tests_failed++;
            $display("FAIL underflow got=%h want=%h", obs, e);
        end
        apply(0, 1, 1, 2'd3, 0);
        e = sb.pop_front();
        tests_run++;
        if (obs !== e || err_zone !== 1'b1 || total_out !== 12'd1) begin
            tests_failed++;
            $display("FAIL bad_zone got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_alarm();
        apply(1, 0, 0, 0, 0); void'(sb.pop_front());
        for (int i = 0; i < 200; i++) begin
            apply(0, 1, 1, 2'(i % 3), 0);
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL alarm_rise step=%0d got=%h want=%h", i, obs, e);
            end
        end
        tests_run++;
        if (alarm !== 1'b1 || total_out !== 12'd200) begin
            tests_failed++;
            $display("FAIL alarm_at_hi alarm=%b total=%0d want 1/200", alarm, total_out);
        end
        for (int i = 0; i < 49; i++) begin
            apply(0, 1, 0, 2'd0, 0);
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL alarm_fall step=%0d got=%h want=%h", i, obs, e);
            end
        end
        tests_run++;
        if (alarm !== 1'b1 || total_out !== 12'd151) begin
            tests_failed++;
            $display("FAIL alarm_hold_151 alarm=%b total=%0d want 1/151", alarm, total_out);
        end
        apply(0, 1, 0, 2'd1, 0);
        e = sb.pop_front();
        tests_run++;
        if (obs !== e || alarm !== 1'b0 || total_out !== 12'd150) begin
            tests_failed++;
            $display("FAIL alarm_at_lo got=%h want=%h", obs, e);
        end
        for (int i = 0; i < 49; i++) begin
            apply(0, 1, 1, 2'd2, 0);
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL alarm_reup step=%0d got=%h want=%h", i, obs, e);
            end
        end
        tests_run++;
        if (alarm !== 1'b0 || total_out !== 12'd199) begin
            tests_failed++;
            $display("FAIL alarm_hold_199 alarm=%b total=%0d want 0/199", alarm, total_out);
        end
    endtask

    task automatic test_back_to_back();
        apply(1, 0, 0, 0, 0); void'(sb.pop_front());
        for (int i = 0; i < 50; i++) begin
            apply(0, 1, 1, 2'd2, 0); void'(sb.pop_front());
        end
        apply(1, 1, 1, 2'd2, 0);
        e = sb.pop_front();
        tests_run++;
        if (obs !== e || obs !== 43'h0) begin
            tests_failed++;
            $display("FAIL midburst_reset got=%h want=%h", obs, e);
        end
        for (int i = 0; i < 256; i++) begin
            apply(0, 1, 1, 2'd0, 0); void'(sb.pop_front());
        end
        apply(0, 1, 1, 2'd0, 1);
        e = sb.pop_front();
        tests_run++;
        if (obs !== e || err_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_vs_set got=%h want=%h", obs, e);
        end
    endtask

    initial begin
        rst = 1'b1; change = 1'b0; on_off = 1'b0; zone = 2'd0; clear_err = 1'b0;
        test_reset();
        test_up_down();
        test_overflow();
        test_underflow_zone();
        test_alarm();
        test_back_to_back();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
